// File: rtl/inst_fetcher.sv
// Byte-serial instruction fetcher: assembles little-endian words into a {pc, inst} FIFO; byte0 issue -> head valid 5 cycles later.
// Starts a word only if it fits in the FIFO; rdy_in=0 freezes all state; jump_en_in flushes the FIFO and drops any in-flight fetch.
module inst_fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        mem_gnt_in,
  output logic        mem_rd_en_out,
  output logic [31:0] mem_a_out,
  input  logic [7:0]  mem_din_in,
  input  logic        jump_en_in,
  input  logic [31:0] jump_pc_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  input  logic        inst_ready_in
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic           pend_q, pend_d;
  logic [1:0]     lane_q, lane_d;
  logic [23:0]    word_q, word_d;
  logic [7:0]     hold_q, hold_d;
  logic           held_q, held_d;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    q_inst_q [QUEUE_DEPTH];
  logic [31:0]    q_pc_q   [QUEUE_DEPTH];

  logic        go, redirect, issue, push, pop, last_cap, start_ok, next_word_ok;
  logic [7:0]  byte_eff;
  logic [31:0] fetch_base;

  assign go       = rdy_in & ~jump_en_in;
  assign redirect = rdy_in & jump_en_in;
  // A byte that arrived while rdy_in was low was parked in hold_q.
  assign byte_eff = held_q ? hold_q : mem_din_in;
  assign last_cap = pend_q & (lane_q == 2'd3);
  assign push     = go & last_cap;
  assign pop      = go & (count_q != '0) & inst_ready_in;
  assign start_ok     = (int'(count_q) + int'(last_cap)) < QUEUE_DEPTH;
  assign next_word_ok = (int'(count_q) + 1) < QUEUE_DEPTH;
  // Byte0 of the next word may issue while the previous word's byte3 is captured.
  assign fetch_base = last_cap ? pc_q + 32'd4 : pc_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && start_ok) begin
          state_d = FETCH;
          issue   = mem_gnt_in;
        end
      end
      FETCH:   issue = go & mem_gnt_in;
      default: state_d = IDLE;
    endcase
    issue = issue & rst_n_in;
    if (issue && byte_idx_q == 2'd3) state_d = next_word_ok ? FETCH : IDLE;
    if (redirect) state_d = IDLE;
  end

  assign mem_rd_en_out  = issue;
  assign mem_a_out      = issue ? fetch_base + {30'd0, byte_idx_q} : 32'd0;
  assign inst_valid_out = (count_q != '0);
  assign inst_out       = q_inst_q[head_q];
  assign inst_pc_out    = q_pc_q[head_q];

  always_comb begin
    byte_idx_d = issue ? byte_idx_q + 2'd1 : byte_idx_q;
    pend_d     = pend_q;
    lane_d     = lane_q;
    hold_d     = hold_q;
    held_d     = held_q;
    word_d     = word_q;
    pc_d       = push ? pc_q + 32'd4 : pc_q;
    head_d     = pop ? head_q + AW'(1) : head_q;
    tail_d     = push ? tail_q + AW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (rdy_in) begin
      pend_d = issue;
      lane_d = issue ? byte_idx_q : lane_q;
      held_d = 1'b0;
    end else if (pend_q && !held_q) begin
      hold_d = mem_din_in;
      held_d = 1'b1;
    end
    if (go && pend_q) begin
      case (lane_q)
        2'd0:    word_d[7:0]   = byte_eff;
        2'd1:    word_d[15:8]  = byte_eff;
        2'd2:    word_d[23:16] = byte_eff;
        default: word_d        = word_q;
      endcase
    end
    if (redirect) begin
      byte_idx_d = 2'd0;
      pend_d     = 1'b0;
      held_d     = 1'b0;
      pc_d       = jump_pc_in;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      byte_idx_q <= 2'd0;
      pend_q     <= 1'b0;
      lane_q     <= 2'd0;
      word_q     <= 24'd0;
      hold_q     <= 8'd0;
      held_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst_q[i] <= 32'd0;
        q_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      pend_q     <= pend_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        q_inst_q[tail_q] <= {byte_eff, word_q};
        q_pc_q[tail_q]   <= pc_q;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized and directed bench for inst_fetcher against a byte-stream / word-stream reference model.
module tb_inst_fetcher;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy, gnt, rd_en, jmp, valid, ready;
  logic [31:0] addr, jpc, inst, ipc;
  logic [7:0]  din;

  always #5 clk = ~clk;

  inst_fetcher #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .mem_gnt_in(gnt),
    .mem_rd_en_out(rd_en), .mem_a_out(addr), .mem_din_in(din),
    .jump_en_in(jmp), .jump_pc_in(jpc), .inst_valid_out(valid),
    .inst_out(inst), .inst_pc_out(ipc), .inst_ready_in(ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0] ram [512];
  function automatic logic [7:0] rb(input logic [31:0] a);
    return ram[a[8:0]];
  endfunction
  function automatic logic [31:0] rw(input logic [31:0] a);
    return {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
  endfunction

  // Reference model: reads form one consecutive byte stream and pops one consecutive
  // word stream, both restarting at the target on a redirect.
  logic [31:0] m_fetch, m_exp_pc, last_a;
  int          m_started, m_popped, pops;
  logic        last_rd, exp_empty;

  task automatic model_clear();
    m_fetch = 32'h0; m_exp_pc = 32'h0; m_started = 0; m_popped = 0;
    last_rd = 1'b0; exp_empty = 1'b0;
  endtask

  task automatic step(input logic g, input logic r, input logic j, input logic [31:0] jp, input logic rq);
    @(negedge clk);
    din   = last_rd ? rb(last_a) : 8'($urandom);
    gnt   = g; rdy = r; jmp = j; jpc = jp; ready = rq;
    #1;
    if (exp_empty) chk("valid_after_jump", 32'(valid), 32'd0);
    exp_empty = 1'b0;
    if (!(r && g && !j)) chk("no_read_when_blocked", 32'(rd_en), 32'd0);
    if (r && j) begin
      m_fetch = jp; m_exp_pc = jp; m_started = 0; m_popped = 0; exp_empty = 1'b1;
    end else if (r) begin
      if (rd_en) begin
        chk("read_addr", addr, m_fetch);
        if (m_fetch[1:0] == 2'd0) begin
          chk("space_rule", 32'(rd_en), 32'((m_started - m_popped) < DEPTH));
          m_started++;
        end
        m_fetch++;
      end
      if (valid && rq) begin
        chk("pop_pc", ipc, m_exp_pc);
        chk("pop_inst", inst, rw(m_exp_pc));
        m_exp_pc += 32'd4; m_popped++; pops++;
      end
    end
    last_rd = rd_en; last_a = addr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b0; gnt = 1'b0; jmp = 1'b0; jpc = 32'h0; ready = 1'b0; din = 8'h0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  initial begin
    int reads_late, p0;
    logic found;
    pops = 0;
    for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;

    // Reset state and first-word latency
    do_reset();
    #1;
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_pc", ipc, 32'd0);
    for (int c = 0; c <= 5; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (c <= 3) chk("t1_rd_en", 32'(rd_en), 32'd1);
      if (c == 4) chk("t1_valid_c4", 32'(valid), 32'd0);
      if (c == 5) begin
        chk("t1_valid_c5", 32'(valid), 32'd1);
        chk("t1_inst", inst, 32'h00100513);
        chk("t1_pc", ipc, 32'h0);
      end
    end

    // Full FIFO stops fetching; one pop admits exactly one more word
    reads_late = 0;
    for (int c = 0; c < 25; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (c >= 17 && rd_en) reads_late++;
    end
    chk("t2_words", 32'(m_started), 32'd4);
    chk("t2_idle_reads", 32'(reads_late), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t2_words_after_pop", 32'(m_started), 32'd5);
    chk("t2_fetch_end", m_fetch, 32'h14);

    // Redirect right after byte2 of pc 8
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (rd_en && addr == 32'hA) found = 1'b1;
    end
    chk("t3_reach_byte2", 32'(found), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_restart_rd", 32'(rd_en), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (valid) begin
        found = 1'b1;
        chk("t3_head_pc", ipc, 32'h100);
        chk("t3_head_inst", inst, rw(32'h100));
      end
    end
    chk("t3_head_seen", 32'(found), 32'd1);

    // Grant withdrawn mid-word
    do_reset();
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_resume_addr", addr, 32'h2);
    p0 = pops;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_progress", 32'((pops - p0) >= 2), 32'd1);

    // Global stall mid-word with a pop pending
    do_reset();
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t5_hold_valid", 32'(valid), 32'd1);
      chk("t5_hold_pc", ipc, 32'h0);
    end
    p0 = pops;
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t5_progress", 32'((pops - p0) >= 3), 32'd1);

    // Asynchronous reset mid-word with two entries queued
    do_reset();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_queued", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_inst", inst, 32'd0);
    chk("t6_rst_pc", ipc, 32'd0);
    chk("t6_rst_rd", 32'(rd_en), 32'd0);
    chk("t6_rst_addr", addr, 32'd0);
    do_reset();
    p0 = pops;
    repeat (30) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t6_restart", 32'((pops - p0) >= 4), 32'd1);

    // Random traffic
    do_reset();
    p0 = pops;
    for (int c = 0; c < 3000; c++)
      step(($urandom % 4) != 0, ($urandom % 8) != 0, ($urandom % 40) == 0,
           {23'd0, 7'($urandom_range(0, 127)), 2'b00}, ($urandom % 3) != 0);
    chk("rand_progress", 32'((pops - p0) > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
